// File: rtl/fft_bitrev_reorder.sv
// fft_bitrev_reorder: ping-pong reorder buffer for the radix-2 SDF FFT output.
//   Frames arrive in bit-reversed order. Each frame leaves in natural order, index 0..FFT_N-1.
//   Latency: index 0 appears 2 enabled edges after the frame's last sample is accepted.
//   Backpressure: none. The consumer must take every out_valid cycle, and the input is never stalled.
//
// Optional feature macro: FFT_REORDER_INDEX_EN adds the out_index port and its pipeline register.
//
// Ports:
//   clk, rst             clock; synchronous active-high reset
//   enable               global clock enable; when low, all state holds and in_valid is ignored
//   in_valid/re/im       input samples in bit-reversed frame order
//   out_valid/re/im      output samples in natural order
//   out_last             marks the sample at index FFT_N-1
//   out_index            natural bin number of the current output (FFT_REORDER_INDEX_EN only)

module fft_bitrev_reorder #(
  parameter  int FFT_N  = 1024,
  parameter  int DATA_W = 16,
  localparam int LOG2N  = $clog2(FFT_N)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     enable,
  input  logic                     in_valid,
  input  logic signed [DATA_W-1:0] in_re,
  input  logic signed [DATA_W-1:0] in_im,
  output logic                     out_valid,
  output logic signed [DATA_W-1:0] out_re,
  output logic signed [DATA_W-1:0] out_im,
  output logic                     out_last
`ifdef FFT_REORDER_INDEX_EN
  ,
  output logic [LOG2N-1:0]         out_index
`endif
);

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_DRAIN = 1'b1;

  localparam logic [LOG2N-1:0] CNT_LAST = LOG2N'(FFT_N - 1);
  localparam logic [LOG2N-1:0] CNT_ONE  = LOG2N'(1);

  function automatic logic [LOG2N-1:0] bit_rev(input logic [LOG2N-1:0] a);
    logic [LOG2N-1:0] r;
    r = '0;
    for (int b = 0; b < LOG2N; b++) begin
      r[b] = a[LOG2N-1-b];
    end
    return r;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [LOG2N-1:0]    wr_cnt_q,  wr_cnt_d;
  logic                wr_bank_q, wr_bank_d;
  logic [0:0]          state_q,   state_d;
  logic [LOG2N-1:0]    rd_cnt_q,  rd_cnt_d;
  logic                rd_bank_q, rd_bank_d;

  // Both banks live in one array; the bank select is the address MSB.
  logic [2*DATA_W-1:0] mem_q [2*FFT_N];
  logic [2*DATA_W-1:0] rd_dat_q;

  // Stage 1 tag, which travels alongside the synchronous RAM read.
  logic                s1_vld_q;
  logic                s1_last_q;

  // Stage 2 output registers.
  logic                out_valid_q;
  logic                out_last_q;
  logic [DATA_W-1:0]   out_re_q;
  logic [DATA_W-1:0]   out_im_q;

`ifdef FFT_REORDER_INDEX_EN
  logic [LOG2N-1:0]    s1_idx_q;
  logic [LOG2N-1:0]    out_idx_q;
`endif

  // ---------------------------------------------------------------------------
  // Write side
  // ---------------------------------------------------------------------------
  logic             wr_acc;
  logic             wr_wrap;
  logic             start;
  logic [LOG2N-1:0] wr_addr;

  assign wr_acc  = enable & in_valid;
  assign wr_wrap = (wr_cnt_q == CNT_LAST);
  // A frame is complete on the edge that accepts its final sample.
  assign start   = wr_acc & wr_wrap;
  assign wr_addr = bit_rev(wr_cnt_q);

  always_comb begin
    wr_cnt_d  = wr_cnt_q;
    wr_bank_d = wr_bank_q;
    if (wr_acc) begin
      // FFT_N is a power of two, so the increment wraps to 0 by itself.
      wr_cnt_d = wr_cnt_q + CNT_ONE;
      if (wr_wrap) begin
        wr_bank_d = ~wr_bank_q;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Read FSM
  // ---------------------------------------------------------------------------
  logic rd_issue;
  logic rd_final;

  assign rd_issue = enable & (state_q == ST_DRAIN);
  assign rd_final = (rd_cnt_q == CNT_LAST);

  always_comb begin
    state_d   = state_q;
    rd_cnt_d  = rd_cnt_q;
    rd_bank_d = rd_bank_q;
    if (start) begin
      // A start event always wins. In DRAIN it can only coincide with the
      // final address, so the next frame continues without a gap. The bank
      // that has just been filled is the current wr_bank.
      state_d   = ST_DRAIN;
      rd_cnt_d  = '0;
      rd_bank_d = wr_bank_q;
    end else if (rd_issue) begin
      rd_cnt_d = rd_cnt_q + CNT_ONE;
      if (rd_final) begin
        state_d = ST_IDLE;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_cnt_q  <= '0;
      wr_bank_q <= 1'b0;
      state_q   <= ST_IDLE;
      rd_cnt_q  <= '0;
      rd_bank_q <= 1'b0;
    end else begin
      wr_cnt_q  <= wr_cnt_d;
      wr_bank_q <= wr_bank_d;
      state_q   <= state_d;
      rd_cnt_q  <= rd_cnt_d;
      rd_bank_q <= rd_bank_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Ping-pong RAM: one write port (fill bank) and one registered read port (drain bank)
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (wr_acc) begin
      mem_q[{wr_bank_q, wr_addr}] <= {in_re, in_im};
    end
    if (enable) begin
      rd_dat_q <= mem_q[{rd_bank_q, rd_cnt_q}];
    end
  end

  // ---------------------------------------------------------------------------
  // Output pipeline: the tag is aligned with the RAM read data, then both are
  // registered together into out_*.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld_q    <= 1'b0;
      s1_last_q   <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q  <= 1'b0;
      out_re_q    <= '0;
      out_im_q    <= '0;
    end else if (enable) begin
      s1_vld_q    <= (state_q == ST_DRAIN);
      s1_last_q   <= (state_q == ST_DRAIN) & rd_final;
      out_valid_q <= s1_vld_q;
      out_last_q  <= s1_last_q;
      // Data is loaded only with valid samples, so idle RAM reads never reach the port.
      if (s1_vld_q) begin
        out_re_q <= rd_dat_q[2*DATA_W-1:DATA_W];
        out_im_q <= rd_dat_q[DATA_W-1:0];
      end
    end
  end

`ifdef FFT_REORDER_INDEX_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_idx_q  <= '0;
      out_idx_q <= '0;
    end else if (enable) begin
      s1_idx_q <= rd_cnt_q;
      if (s1_vld_q) begin
        out_idx_q <= s1_idx_q;
      end
    end
  end

  assign out_index = out_idx_q;
`endif

  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_re    = out_re_q;
  assign out_im    = out_im_q;

endmodule

// File: tb/tb_fft_bitrev_reorder.sv
// Directed bench for fft_bitrev_reorder with FFT_N=8. Expected output order
// comes from a hand-written bit-reversal table.

module tb_fft_bitrev_reorder;

  localparam int N = 8;
  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                enable;
  logic                in_valid;
  logic signed [W-1:0] in_re;
  logic signed [W-1:0] in_im;
  logic                out_valid;
  logic signed [W-1:0] out_re;
  logic signed [W-1:0] out_im;
  logic                out_last;
`ifdef FFT_REORDER_INDEX_EN
  logic [2:0]          out_index;
`endif

  int n_assert = 0;
  int n_fail   = 0;

  // Natural index i holds the sample that arrived at position bitrev3(i).
  int perm [N] = '{0, 4, 2, 6, 1, 5, 3, 7};

  always #5 clk = ~clk;

  fft_bitrev_reorder #(.FFT_N(N), .DATA_W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .enable    (enable),
    .in_valid  (in_valid),
    .in_re     (in_re),
    .in_im     (in_im),
    .out_valid (out_valid),
    .out_re    (out_re),
    .out_im    (out_im),
    .out_last  (out_last)
`ifdef FFT_REORDER_INDEX_EN
    ,
    .out_index (out_index)
`endif
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic vld, input int v);
    in_valid = vld;
    in_re    = W'(v);
    in_im    = W'(-v);
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %b expected %b", tag, obs, exp);
    end
  endtask

  task automatic chk_word(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, $signed(obs), $signed(exp));
    end
  endtask

`ifdef FFT_REORDER_INDEX_EN
  task automatic chk_idx(input string tag, input logic [2:0] obs, input logic [2:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask
`endif

  // Checks valid every cycle. Checks data, last and index only when a sample is expected.
  task automatic expect_out(input string tag, input logic vld, input int re,
                            input logic last, input int idx);
    chk_bit({tag, " valid"}, out_valid, vld);
    if (vld) begin
      chk_word({tag, " re"}, out_re, W'(re));
      chk_word({tag, " im"}, out_im, W'(-re));
      chk_bit({tag, " last"}, out_last, last);
`ifdef FFT_REORDER_INDEX_EN
      chk_idx({tag, " index"}, out_index, 3'(idx));
`endif
    end
  endtask

  initial begin
    int j;

    // ---- reset state ----
    rst = 1'b1; enable = 1'b1;
    drive(1'b0, 0);
    tick(); tick();
    chk_bit("reset out_valid", out_valid, 1'b0);
    chk_bit("reset out_last", out_last, 1'b0);
    chk_word("reset out_re", out_re, '0);
    chk_word("reset out_im", out_im, '0);
`ifdef FFT_REORDER_INDEX_EN
    chk_idx("reset out_index", out_index, 3'd0);
`endif
    rst = 1'b0;

    // ---- test 1: single frame, re=k, im=-k ----
    for (int k = 0; k < N; k++) begin
      drive(1'b1, k);
      tick();
      expect_out("t1 fill", 1'b0, 0, 1'b0, 0);
    end
    drive(1'b0, 0);
    tick();
    expect_out("t1 latency", 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < N; i++) begin
      tick();
      expect_out($sformatf("t1 out%0d", i), 1'b1, perm[i], (i == N-1), i);
    end
    tick();
    expect_out("t1 after", 1'b0, 0, 1'b0, 0);

    // ---- test 2: three frames back-to-back, no gap on output ----
    for (int c = 0; c < 34; c++) begin
      if (c < 24) drive(1'b1, c);
      else        drive(1'b0, 0);
      tick();
      if (c >= 9 && c <= 32) begin
        j = c - 9;
        expect_out($sformatf("t2 c%0d", c), 1'b1, (j / N) * N + perm[j % N],
                   (j % N == N-1), j % N);
      end else begin
        expect_out($sformatf("t2 c%0d", c), 1'b0, 0, 1'b0, 0);
      end
    end

    // ---- test 3: in_valid toggling 1,0,1,0 within a frame ----
    for (int c = 0; c < 25; c++) begin
      if (c < 16) drive((c % 2) == 0, c / 2);
      else        drive(1'b0, 0);
      tick();
      if (c >= 16 && c <= 23) begin
        expect_out($sformatf("t3 c%0d", c), 1'b1, perm[c-16], (c == 23), c - 16);
      end else begin
        expect_out($sformatf("t3 c%0d", c), 1'b0, 0, 1'b0, 0);
      end
    end

    // ---- test 4: enable low for 3 cycles mid-drain ----
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 100 + k);
      tick();
    end
    drive(1'b0, 0);
    tick();
    expect_out("t4 latency", 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < 4; i++) begin
      tick();
      expect_out($sformatf("t4 out%0d", i), 1'b1, 100 + perm[i], 1'b0, i);
    end
    enable = 1'b0;
    for (int r = 0; r < 3; r++) begin
      tick();
      expect_out($sformatf("t4 hold%0d", r), 1'b1, 100 + perm[3], 1'b0, 3);
    end
    enable = 1'b1;
    for (int i = 4; i < N; i++) begin
      tick();
      expect_out($sformatf("t4 out%0d", i), 1'b1, 100 + perm[i], (i == N-1), i);
    end
    tick();
    expect_out("t4 after", 1'b0, 0, 1'b0, 0);

    // ---- test 5: rst mid-drain discards the remainder ----
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 300 + k);
      tick();
    end
    drive(1'b0, 0);
    tick(); tick(); tick();
    expect_out("t5 out1", 1'b1, 300 + perm[1], 1'b0, 1);
    rst = 1'b1;
    tick();
    expect_out("t5 rst", 1'b0, 0, 1'b0, 0);
    rst = 1'b0;
    for (int r = 0; r < 10; r++) begin
      tick();
      expect_out($sformatf("t5 quiet%0d", r), 1'b0, 0, 1'b0, 0);
    end

    // ---- test 6: rst after 5 samples, then a fresh frame ----
    for (int k = 0; k < 5; k++) begin
      drive(1'b1, 50 + k);
      tick();
    end
    drive(1'b0, 0);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    for (int k = 0; k < N; k++) begin
      drive(1'b1, 200 + k);
      tick();
      expect_out($sformatf("t6 fill%0d", k), 1'b0, 0, 1'b0, 0);
    end
    drive(1'b0, 0);
    tick();
    expect_out("t6 latency", 1'b0, 0, 1'b0, 0);
    for (int i = 0; i < N; i++) begin
      tick();
      expect_out($sformatf("t6 out%0d", i), 1'b1, 200 + perm[i], (i == N-1), i);
    end
    tick();
    expect_out("t6 after", 1'b0, 0, 1'b0, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
